// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one downstream APB4 slave port among NumReq upstream APB4 masters.
// The winning access is replayed downstream with a fresh setup and access phase.

package apb_rr_arbiter_pkg;

  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;

  typedef enum logic [1:0] {
    Idle   = 2'd0,
    Setup  = 2'd1,
    Access = 2'd2
  } apb_rr_state_e;

endpackage

module apb_rr_arbiter
  import apb_rr_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter type         req_t  = apb_req_t,
  parameter type         resp_t = apb_resp_t,
  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic            pclk_i,
  input  logic            preset_ni,
  input  req_t            slv_req_i  [NumReq],
  output resp_t           slv_resp_o [NumReq],
  output req_t            mst_req_o,
  input  resp_t           mst_resp_i,
  output apb_rr_state_e   dbg_state_o,
  output logic [IdxW-1:0] dbg_idx_o,
  output logic [IdxW-1:0] dbg_ptr_o
);

  // Handshake: an upstream request is pending while psel & penable are high; it is
  // consumed only in the cycle its own pready is returned high. Downstream follows
  // plain APB4: setup for one cycle, then access held until the slave's pready.

  apb_rr_state_e   fsm_q, fsm_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] ptr_q, ptr_d;

  logic [NumReq-1:0] pending;
  logic [NumReq-1:0] resp_pready;
  logic [IdxW-1:0]   winner;
  logic              any_pending;
  logic              complete;
  int unsigned       scan_j;

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      pending[i] = slv_req_i[i].psel & slv_req_i[i].penable;
    end
  end

  // Scan starts at ptr_q and wraps, so the first hit is the round-robin winner.
  always_comb begin
    winner      = '0;
    any_pending = 1'b0;
    scan_j      = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      scan_j = 32'(ptr_q) + k;
      if (scan_j >= NumReq) begin
        scan_j = scan_j - NumReq;
      end
      if (!any_pending && pending[scan_j]) begin
        any_pending = 1'b1;
        winner      = IdxW'(scan_j);
      end
    end
  end

  assign complete = (fsm_q == Access) && mst_resp_i.pready;

  always_comb begin
    fsm_d = fsm_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    unique case (fsm_q)
      Idle: begin
        if (any_pending) begin
          idx_d = winner;
          fsm_d = Setup;
        end
      end
      Setup: begin
        fsm_d = Access;
      end
      Access: begin
        if (mst_resp_i.pready) begin
          fsm_d = Idle;
          ptr_d = (idx_q == IdxW'(NumReq - 1)) ? '0 : idx_q + 1'b1;
        end
      end
      default: begin
        fsm_d = Idle;
      end
    endcase
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      fsm_q <= Idle;
      idx_q <= '0;
      ptr_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
    end
  end

  // Address/data follow the held winner; only the FSM decides psel/penable.
  always_comb begin
    mst_req_o         = slv_req_i[idx_q];
    mst_req_o.psel    = (fsm_q == Setup) || (fsm_q == Access);
    mst_req_o.penable = (fsm_q == Access);
  end

  // A winner that dropped psel mid-transfer gets nothing back.
  always_comb begin
    resp_pready = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      slv_resp_o[i]  = '0;
      resp_pready[i] = complete && (idx_q == IdxW'(i)) && slv_req_i[i].psel;
      if (resp_pready[i]) begin
        slv_resp_o[i] = mst_resp_i;
      end
    end
  end

  assign dbg_state_o = fsm_q;
  assign dbg_idx_o   = idx_q;
  assign dbg_ptr_o   = ptr_q;

  a_setup_to_access: assert property (@(posedge pclk_i) disable iff (!preset_ni)
    fsm_q == Setup |=> fsm_q == Access);

  a_winner_held: assert property (@(posedge pclk_i) disable iff (!preset_ni)
    fsm_q != Idle |=> $stable(idx_q) || fsm_q == Setup);

  a_single_response: assert property (@(posedge pclk_i) disable iff (!preset_ni)
    $onehot0(resp_pready));

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: a 2-requester instance with a wait-state/error
// capable slave model, plus a 4-requester instance for grant-order checking.

module tb_apb_rr_arbiter;
  import apb_rr_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  apb_req_t      req2 [2];
  apb_resp_t     resp2 [2];
  apb_req_t      mreq2;
  apb_resp_t     mresp2;
  apb_rr_state_e st2;
  logic          idx2, ptr2;

  apb_req_t      req4 [4];
  apb_resp_t     resp4 [4];
  apb_req_t      mreq4;
  apb_resp_t     mresp4;
  apb_rr_state_e st4;
  logic [1:0]    idx4, ptr4;

  apb_rr_arbiter #(.NumReq(2)) dut2 (
    .pclk_i(clk), .preset_ni(rst_n),
    .slv_req_i(req2), .slv_resp_o(resp2),
    .mst_req_o(mreq2), .mst_resp_i(mresp2),
    .dbg_state_o(st2), .dbg_idx_o(idx2), .dbg_ptr_o(ptr2)
  );

  apb_rr_arbiter #(.NumReq(4)) dut4 (
    .pclk_i(clk), .preset_ni(rst_n),
    .slv_req_i(req4), .slv_resp_o(resp4),
    .mst_req_o(mreq4), .mst_resp_i(mresp4),
    .dbg_state_o(st4), .dbg_idx_o(idx4), .dbg_ptr_o(ptr4)
  );

  // ---------------- bookkeeping ----------------
  int n_chk = 0;
  int n_fail = 0;
  logic [34:0] exp_q [$];   // {port[1:0], pslverr, prdata}
  logic [31:0] grant_q [$]; // expected downstream setup address for dut4
  logic [34:0] e2;
  logic [31:0] g4;
  logic [31:0] last_addr4 = 32'h0;
  int seen4 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave models ----------------
  logic [31:0] mem2 [256];
  int   wait_n = 0;
  logic err_en = 1'b0;
  int   wait_cnt;

  always_comb begin
    mresp2 = '0;
    if (mreq2.psel && mreq2.penable && (wait_cnt == wait_n)) begin
      mresp2.pready  = 1'b1;
      mresp2.pslverr = err_en;
      if (!mreq2.pwrite) mresp2.prdata = mem2[mreq2.paddr[7:0]];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (mreq2.psel && mreq2.penable && !mresp2.pready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always @(posedge clk) begin
    if (mreq2.psel && mreq2.penable && mresp2.pready && mreq2.pwrite)
      mem2[mreq2.paddr[7:0]] = mreq2.pwdata;
  end

  always_comb begin
    mresp4 = '0;
    if (mreq4.psel && mreq4.penable) begin
      mresp4.pready = 1'b1;
      mresp4.prdata = {16'h0, mreq4.paddr[15:0]};
    end
  end

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (resp2[i].pready) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 64'(i + 1), 64'd0);
        end else begin
          e2 = exp_q.pop_front();
          chk("resp_port", 64'(i), 64'(e2[34:33]));
          chk("resp_pslverr", 64'(resp2[i].pslverr), 64'(e2[32]));
          chk("resp_prdata", 64'(resp2[i].prdata), 64'(e2[31:0]));
          chk("resp_other_quiet", 64'(resp2[1-i]), 64'd0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mreq4.psel && !mreq4.penable) begin
      if (grant_q.size() == 0) begin
        chk("grant4_extra", 64'(mreq4.paddr), 64'd0);
      end else begin
        g4 = grant_q.pop_front();
        chk("grant4_order", 64'(mreq4.paddr), 64'(g4));
      end
      last_addr4 = mreq4.paddr;
      seen4++;
    end
    for (int i = 0; i < 4; i++) begin
      if (resp4[i].pready) chk("resp4_winner", 64'(32'h100 + 4 * i), 64'(last_addr4));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apb_xfer(input int p, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data);
    bit done;
    @(posedge clk); #1;
    req2[p].paddr   = addr;
    req2[p].pwrite  = wr;
    req2[p].pwdata  = data;
    req2[p].pstrb   = 4'hF;
    req2[p].pprot   = 3'd0;
    req2[p].psel    = 1'b1;
    req2[p].penable = 1'b0;
    @(posedge clk); #1;
    req2[p].penable = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (resp2[p].pready) done = 1'b1;
    end
    if (!done) chk("xfer_timeout", 64'(p + 1), 64'd0);
    @(posedge clk); #1;
    req2[p].psel    = 1'b0;
    req2[p].penable = 1'b0;
  endtask

  task automatic wait_access(input string name);
    bit hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      @(negedge clk);
      if (mreq2.psel && mreq2.penable) hit = 1'b1;
    end
    if (!hit) chk(name, 64'd0, 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit hit;
    for (int i = 0; i < 256; i++) mem2[i] = 32'hA000_0000 | 32'(i);
    for (int i = 0; i < 2; i++) req2[i] = '0;
    for (int i = 0; i < 4; i++) req4[i] = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_mst_sel", 64'({mreq2.psel, mreq2.penable}), 64'd0);
    chk("rst_resp0", 64'(resp2[0]), 64'd0);
    chk("rst_resp1", 64'(resp2[1]), 64'd0);
    chk("rst_state", 64'(st2), 64'(Idle));
    chk("rst_idx_ptr", 64'({idx2, ptr2}), 64'd0);
    chk("rst_mst4_sel", 64'({mreq4.psel, mreq4.penable}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // single write, latency T / T+1 / T+2
    exp_q.push_back({2'd0, 1'b0, 32'h0});
    @(posedge clk); #1;
    req2[0].paddr = 32'h10; req2[0].pwrite = 1'b1; req2[0].pwdata = 32'hCAFE;
    req2[0].pstrb = 4'hF;   req2[0].psel = 1'b1;   req2[0].penable = 1'b0;
    @(posedge clk); #1 req2[0].penable = 1'b1;
    @(negedge clk);
    chk("wr_T_no_psel", 64'(mreq2.psel), 64'd0);
    @(negedge clk);
    chk("wr_T1_setup", 64'({mreq2.psel, mreq2.penable}), 64'b10);
    chk("wr_T1_addr", 64'(mreq2.paddr), 64'h10);
    @(negedge clk);
    chk("wr_T2_access", 64'({mreq2.psel, mreq2.penable}), 64'b11);
    chk("wr_T2_pready0", 64'(resp2[0].pready), 64'd1);
    chk("wr_T2_resp1_zero", 64'(resp2[1]), 64'd0);
    @(posedge clk); #1 req2[0].psel = 1'b0; req2[0].penable = 1'b0;
    @(negedge clk);
    chk("wr_idle_after", 64'(st2), 64'(Idle));
    chk("wr_ptr_after", 64'(ptr2), 64'd1);
    chk("wr_mem", 64'(mem2[8'h10]), 64'hCAFE);

    // write from requester 1 brings ptr back to 0
    exp_q.push_back({2'd1, 1'b0, 32'h0});
    apb_xfer(1, 1'b1, 32'h20, 32'h1234_5678);
    @(negedge clk);
    chk("wr1_ptr_after", 64'(ptr2), 64'd0);

    // simultaneous reads, ptr=0: requester 0 first, then 1
    exp_q.push_back({2'd0, 1'b0, 32'hCAFE});
    exp_q.push_back({2'd1, 1'b0, 32'h1234_5678});
    fork
      apb_xfer(0, 1'b0, 32'h10, 32'h0);
      apb_xfer(1, 1'b0, 32'h20, 32'h0);
    join
    @(negedge clk);
    chk("rr_ptr_after", 64'(ptr2), 64'd0);

    // three wait states with error, requester 1
    wait_n = 3; err_en = 1'b1;
    exp_q.push_back({2'd1, 1'b1, 32'hA000_0030});
    fork
      apb_xfer(1, 1'b0, 32'h30, 32'h0);
      begin
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
          @(negedge clk);
          if (mreq2.psel && !mreq2.penable) hit = 1'b1;
        end
        if (!hit) chk("ws_setup_timeout", 64'd0, 64'd1);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("ws_held", 64'({mreq2.psel, mreq2.penable}), 64'b11);
          chk("ws_addr_stable", 64'(mreq2.paddr), 64'h30);
          chk("ws_pready_cycle", 64'(resp2[1].pready), 64'(k == 3));
        end
      end
    join
    wait_n = 0; err_en = 1'b0;

    // reset during access abandons the transfer; pending request re-served after release
    wait_n = 5;
    exp_q.push_back({2'd0, 1'b0, 32'hCAFE});
    fork
      apb_xfer(0, 1'b0, 32'h10, 32'h0);
      begin
        wait_access("rst_access_timeout");
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_sel", 64'({mreq2.psel, mreq2.penable}), 64'd0);
        chk("rst_mid_pready", 64'({resp2[0].pready, resp2[1].pready}), 64'd0);
        chk("rst_mid_state", 64'(st2), 64'(Idle));
        chk("rst_mid_ptr", 64'(ptr2), 64'd0);
        wait_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    @(negedge clk);
    chk("rst_recover_ptr", 64'(ptr2), 64'd1);

    // winner drops psel during access: downstream completes, nobody gets pready
    wait_n = 2;
    @(posedge clk); #1;
    req2[1].paddr = 32'h20; req2[1].pwrite = 1'b0;
    req2[1].psel = 1'b1;    req2[1].penable = 1'b0;
    @(posedge clk); #1 req2[1].penable = 1'b1;
    wait_access("viol_access_timeout");
    #1 req2[1].psel = 1'b0; req2[1].penable = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      if (mresp2.pready) hit = 1'b1;
      else @(negedge clk);
    end
    if (!hit) chk("viol_pready_timeout", 64'd0, 64'd1);
    chk("viol_mst_sel", 64'({mreq2.psel, mreq2.penable}), 64'b11);
    chk("viol_no_pready", 64'({resp2[0].pready, resp2[1].pready}), 64'd0);
    @(negedge clk);
    chk("viol_idle_after", 64'(st2), 64'(Idle));
    wait_n = 0;

    // NumReq=4, all continuously pending: grant order 0,1,2,3,0,1,2,3
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) grant_q.push_back(32'h100 + 32'(4 * i));
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      req4[i].paddr = 32'h100 + 32'(4 * i);
      req4[i].pstrb = 4'hF;
      req4[i].psel  = 1'b1;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) req4[i].penable = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 80 && !hit; n++) begin
      @(posedge clk);
      if (seen4 == 8) hit = 1'b1;
    end
    if (!hit) chk("grant4_timeout", 64'(seen4), 64'd8);
    @(negedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      req4[i].psel    = 1'b0;
      req4[i].penable = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("grant4_ptr_after", 64'(ptr4), 64'd0);

    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    chk("grant4_drain", 64'(grant_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
